// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate game sequencer for the VGA Pong display.
// Owns ball, paddle, score and serve/play/game-over state. It advances once per
// frame on a registered strobe derived from the falling edge of vertical sync.
module pong_game_ctrl #(
    parameter int VIDEO_W      = 640,
    parameter int FIELD_TOP    = 62,
    parameter int FIELD_BOT    = 468,
    parameter int BALL_SIZE    = 12,
    parameter int BALL_SPEED   = 2,
    parameter int PAD_X1       = 16,
    parameter int PAD_X2       = 620,
    parameter int PAD_W        = 4,
    parameter int PAD_H        = 64,
    parameter int PAD_SPEED    = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        iVGA_CLK,
    input  logic        iRST,
    input  logic        iVS,
    input  logic        iSTART,
    input  logic        iP1_UP,
    input  logic        iP1_DN,
    input  logic        iP2_UP,
    input  logic        iP2_DN,
    output logic [10:0] oBALL_X,
    output logic [9:0]  oBALL_Y,
    output logic [9:0]  oPAD1_Y,
    output logic [9:0]  oPAD2_Y,
    output logic [3:0]  oSCORE1,
    output logic [3:0]  oSCORE2,
    output logic [2:0]  oSTATE,
    output logic        oWINNER,
    output logic        oFRAME_TICK
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    // Geometry as 12-bit signed constants so every position compare is signed.
    localparam logic signed [11:0] TOP_Y      = 12'(FIELD_TOP);
    localparam logic signed [11:0] BALL_MAX_Y = 12'(FIELD_BOT - BALL_SIZE);
    localparam logic signed [11:0] PAD_MAX_Y  = 12'(FIELD_BOT - PAD_H);
    localparam logic signed [11:0] BALL_S     = 12'(BALL_SIZE);
    localparam logic signed [11:0] SPEED_S    = 12'(BALL_SPEED);
    localparam logic signed [11:0] PAD_STEP   = 12'(PAD_SPEED);
    localparam logic signed [11:0] PAD_H_S    = 12'(PAD_H);
    localparam logic signed [11:0] LEFT_FACE  = 12'(PAD_X1 + PAD_W);
    localparam logic signed [11:0] RIGHT_FACE = 12'(PAD_X2);
    localparam logic signed [11:0] RIGHT_STOP = 12'(PAD_X2 - BALL_SIZE);
    localparam logic signed [11:0] RIGHT_EDGE = 12'(VIDEO_W - BALL_SIZE);
    localparam logic signed [11:0] CENTRE_X   = 12'((VIDEO_W - BALL_SIZE) / 2);
    localparam logic signed [11:0] CENTRE_Y   = 12'(FIELD_TOP + (FIELD_BOT - FIELD_TOP - BALL_SIZE) / 2);
    localparam logic signed [11:0] PAD_HOME   = 12'(FIELD_TOP + (FIELD_BOT - FIELD_TOP - PAD_H) / 2);
    localparam logic [3:0]         WIN_S      = 4'(WIN_SCORE);
    localparam int                 CNT_W      = $clog2(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SERVE_FRAMES - 1);

    // Score increment that saturates at the winning score.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN_S) ? WIN_S : s + 4'd1;
    endfunction

    // One frame of paddle motion, clamped to the playfield; both/neither holds.
    function automatic logic signed [11:0] pad_step(input logic signed [11:0] y,
                                                    input logic up, input logic dn);
        logic signed [11:0] t;
        t = y;
        if (up && !dn) begin
            t = y - PAD_STEP;
            if (t < TOP_Y) t = TOP_Y;
        end else if (dn && !up) begin
            t = y + PAD_STEP;
            if (t > PAD_MAX_Y) t = PAD_MAX_Y;
        end
        return t;
    endfunction

    logic vs1, vs2, tick;
    logic vs_fall;

    state_t                state, state_nxt;
    logic signed [11:0]    ball_x, ball_x_nxt, ball_y, ball_y_nxt;
    logic signed [11:0]    dx, dx_nxt, dy, dy_nxt;
    logic signed [11:0]    pad1_y, pad1_nxt, pad2_y, pad2_nxt;
    logic [3:0]            score1, score1_nxt, score2, score2_nxt;
    logic                  winner, winner_nxt;
    logic                  serve_right, serve_right_nxt;
    logic [CNT_W-1:0]      serve_cnt, cnt_nxt;

    logic signed [11:0]    nx, ny;
    logic                  hit1, hit2;

    assign vs_fall = vs2 & ~vs1;

    // Candidate next ball position; paddle contact uses the current (pre-move) rows.
    assign nx   = ball_x + dx;
    assign ny   = ball_y + dy;
    assign hit1 = (nx <= LEFT_FACE) && (ball_y + BALL_S > pad1_y) && (ball_y < pad1_y + PAD_H_S);
    assign hit2 = (nx + BALL_S >= RIGHT_FACE) && (ball_y + BALL_S > pad2_y) && (ball_y < pad2_y + PAD_H_S);

    // Sync iVS into the pixel domain and register the one-cycle frame strobe.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            vs1  <= 1'b1;
            vs2  <= 1'b1;
            tick <= 1'b0;
        end else begin
            vs1  <= iVS;
            vs2  <= vs1;
            tick <= vs_fall;
        end
    end

    // Game state register.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            state       <= S_IDLE;
            ball_x      <= CENTRE_X;
            ball_y      <= CENTRE_Y;
            dx          <= -SPEED_S;
            dy          <= SPEED_S;
            pad1_y      <= PAD_HOME;
            pad2_y      <= PAD_HOME;
            score1      <= 4'd0;
            score2      <= 4'd0;
            winner      <= 1'b0;
            serve_right <= 1'b0;
            serve_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            ball_x      <= ball_x_nxt;
            ball_y      <= ball_y_nxt;
            dx          <= dx_nxt;
            dy          <= dy_nxt;
            pad1_y      <= pad1_nxt;
            pad2_y      <= pad2_nxt;
            score1      <= score1_nxt;
            score2      <= score2_nxt;
            winner      <= winner_nxt;
            serve_right <= serve_right_nxt;
            serve_cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: start requests act on any cycle, everything else on the frame strobe.
    always_comb begin
        state_nxt       = state;
        ball_x_nxt      = ball_x;
        ball_y_nxt      = ball_y;
        dx_nxt          = dx;
        dy_nxt          = dy;
        pad1_nxt        = pad1_y;
        pad2_nxt        = pad2_y;
        score1_nxt      = score1;
        score2_nxt      = score2;
        winner_nxt      = winner;
        serve_right_nxt = serve_right;
        cnt_nxt         = serve_cnt;

        if (iSTART && (state == S_IDLE || state == S_OVER)) begin
            state_nxt       = S_SERVE;
            score1_nxt      = 4'd0;
            score2_nxt      = 4'd0;
            winner_nxt      = 1'b0;
            serve_right_nxt = 1'b0;
            cnt_nxt         = '0;
            ball_x_nxt      = CENTRE_X;
            ball_y_nxt      = CENTRE_Y;
        end else if (tick) begin
            case (state)
                S_SERVE: begin
                    ball_x_nxt = CENTRE_X;
                    ball_y_nxt = CENTRE_Y;
                    pad1_nxt   = pad_step(pad1_y, iP1_UP, iP1_DN);
                    pad2_nxt   = pad_step(pad2_y, iP2_UP, iP2_DN);
                    if (serve_cnt == CNT_LAST) begin
                        state_nxt = S_PLAY;
                        cnt_nxt   = '0;
                        dx_nxt    = serve_right ? SPEED_S : -SPEED_S;
                        dy_nxt    = SPEED_S;
                    end else begin
                        cnt_nxt = serve_cnt + CNT_W'(1);
                    end
                end
                S_PLAY: begin
                    pad1_nxt = pad_step(pad1_y, iP1_UP, iP1_DN);
                    pad2_nxt = pad_step(pad2_y, iP2_UP, iP2_DN);
                    if (ny <= TOP_Y) begin
                        ball_y_nxt = TOP_Y;
                        dy_nxt     = SPEED_S;
                    end else if (ny >= BALL_MAX_Y) begin
                        ball_y_nxt = BALL_MAX_Y;
                        dy_nxt     = -SPEED_S;
                    end else begin
                        ball_y_nxt = ny;
                    end
                    if (dx[11]) begin
                        if (hit1) begin
                            ball_x_nxt = LEFT_FACE;
                            dx_nxt     = SPEED_S;
                        end else if (nx <= 12'sd0) begin
                            score2_nxt      = sat_inc(score2);
                            serve_right_nxt = 1'b0;
                            state_nxt       = S_POINT;
                        end else begin
                            ball_x_nxt = nx;
                        end
                    end else begin
                        if (hit2) begin
                            ball_x_nxt = RIGHT_STOP;
                            dx_nxt     = -SPEED_S;
                        end else if (nx >= RIGHT_EDGE) begin
                            score1_nxt      = sat_inc(score1);
                            serve_right_nxt = 1'b1;
                            state_nxt       = S_POINT;
                        end else begin
                            ball_x_nxt = nx;
                        end
                    end
                end
                S_POINT: begin
                    if (score1 == WIN_S || score2 == WIN_S) begin
                        state_nxt  = S_OVER;
                        winner_nxt = (score2 == WIN_S);
                    end else begin
                        state_nxt  = S_SERVE;
                        ball_x_nxt = CENTRE_X;
                        ball_y_nxt = CENTRE_Y;
                    end
                end
                default: ;
            endcase
        end
    end

    // On-screen values never reach the sign/headroom bits of the 12-bit registers.
    logic unused_hi;
    assign unused_hi = ^{ball_x[11], ball_y[11:10], pad1_y[11:10], pad2_y[11:10]};

    assign oBALL_X     = ball_x[10:0];
    assign oBALL_Y     = ball_y[9:0];
    assign oPAD1_Y     = pad1_y[9:0];
    assign oPAD2_Y     = pad2_y[9:0];
    assign oSCORE1     = score1;
    assign oSCORE2     = score2;
    assign oSTATE      = state;
    assign oWINNER     = winner;
    assign oFRAME_TICK = tick;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: frame-level reference model feeding a scoreboard
// queue; a monitor compares the DUT state after every frame strobe.
module tb_pong_game_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vs = 1'b1;
    logic        start = 1'b0;
    logic        p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
    logic [10:0] ball_x;
    logic [9:0]  ball_y, pad1_y, pad2_y;
    logic [3:0]  score1, score2;
    logic [2:0]  state;
    logic        winner, frame_tick;

    pong_game_ctrl dut (
        .iVGA_CLK    (clk),
        .iRST        (rst),
        .iVS         (vs),
        .iSTART      (start),
        .iP1_UP      (p1_up),
        .iP1_DN      (p1_dn),
        .iP2_UP      (p2_up),
        .iP2_DN      (p2_dn),
        .oBALL_X     (ball_x),
        .oBALL_Y     (ball_y),
        .oPAD1_Y     (pad1_y),
        .oPAD2_Y     (pad2_y),
        .oSCORE1     (score1),
        .oSCORE2     (score2),
        .oSTATE      (state),
        .oWINNER     (winner),
        .oFRAME_TICK (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [9:0]  p1;
        logic [9:0]  p2;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [2:0]  st;
        logic        w;
    } snap_t;

    snap_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    tick_count = 0;

    // Reference model: game rules applied one frame at a time.
    int m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_s1, m_s2, m_st, m_w, m_cnt, m_serve_right;

    function automatic snap_t dut_view();
        snap_t a;
        a.x = ball_x; a.y = ball_y; a.p1 = pad1_y; a.p2 = pad2_y;
        a.s1 = score1; a.s2 = score2; a.st = state; a.w = winner;
        return a;
    endfunction

    function automatic snap_t model_view();
        snap_t e;
        e.x = 11'(m_bx); e.y = 10'(m_by); e.p1 = 10'(m_p1); e.p2 = 10'(m_p2);
        e.s1 = 4'(m_s1); e.s2 = 4'(m_s2); e.st = 3'(m_st); e.w = (m_w != 0);
        return e;
    endfunction

    function automatic int paddle(input int y, input bit up, input bit dn);
        if (up && !dn) return (y - 4 < 62) ? 62 : y - 4;
        if (dn && !up) return (y + 4 > 404) ? 404 : y + 4;
        return y;
    endfunction

    function automatic bit covers(input int by, input int py);
        return (by + 12 > py) && (by < py + 64);
    endfunction

    task automatic model_reset();
        m_bx = 314; m_by = 259; m_dx = -2; m_dy = 2; m_p1 = 233; m_p2 = 233;
        m_s1 = 0; m_s2 = 0; m_st = 0; m_w = 0; m_cnt = 0; m_serve_right = 0;
    endtask

    task automatic model_start();
        if (m_st == 0 || m_st == 4) begin
            m_st = 1; m_s1 = 0; m_s2 = 0; m_w = 0; m_serve_right = 0; m_cnt = 0;
            m_bx = 314; m_by = 259;
        end
    endtask

    task automatic model_frame(input bit u1, input bit d1, input bit u2, input bit d2);
        int nx, ny, old_y;
        case (m_st)
            1: begin
                m_bx = 314; m_by = 259;
                m_p1 = paddle(m_p1, u1, d1);
                m_p2 = paddle(m_p2, u2, d2);
                if (m_cnt == 59) begin
                    m_st = 2; m_cnt = 0; m_dx = m_serve_right ? 2 : -2; m_dy = 2;
                end else begin
                    m_cnt++;
                end
            end
            2: begin
                old_y = m_by;
                nx = m_bx + m_dx;
                ny = m_by + m_dy;
                if (ny <= 62) begin m_by = 62; m_dy = 2; end
                else if (ny >= 456) begin m_by = 456; m_dy = -2; end
                else m_by = ny;
                if (m_dx < 0) begin
                    if (nx <= 20 && covers(old_y, m_p1)) begin m_bx = 20; m_dx = 2; end
                    else if (nx <= 0) begin m_s2 = (m_s2 >= 9) ? 9 : m_s2 + 1; m_serve_right = 0; m_st = 3; end
                    else m_bx = nx;
                end else begin
                    if (nx + 12 >= 620 && covers(old_y, m_p2)) begin m_bx = 608; m_dx = -2; end
                    else if (nx >= 628) begin m_s1 = (m_s1 >= 9) ? 9 : m_s1 + 1; m_serve_right = 1; m_st = 3; end
                    else m_bx = nx;
                end
                m_p1 = paddle(m_p1, u1, d1);
                m_p2 = paddle(m_p2, u2, d2);
            end
            3: begin
                if (m_s1 == 9 || m_s2 == 9) begin m_st = 4; m_w = (m_s2 == 9); end
                else begin m_st = 1; m_bx = 314; m_by = 259; end
            end
            default: ;
        endcase
    endtask

    task automatic check_snap(input string name, input snap_t a, input snap_t e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got x=%0d y=%0d p1=%0d p2=%0d s1=%0d s2=%0d st=%0d w=%0d, want x=%0d y=%0d p1=%0d p2=%0d s1=%0d s2=%0d st=%0d w=%0d",
                     name, a.x, a.y, a.p1, a.p2, a.s1, a.s2, a.st, a.w,
                     e.x, e.y, e.p1, e.p2, e.s1, e.s2, e.st, e.w);
        end
    endtask

    task automatic check_int(input string name, input int actual, input int want);
        n_checks++;
        if (actual != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", name, actual, want);
        end
    endtask

    // Monitor: after every frame strobe, pop the model's prediction and compare.
    initial begin : monitor
        bit    tick_prev;
        snap_t e;
        tick_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL frame_update: strobe with no prediction queued");
                end else begin
                    e = exp_q.pop_front();
                    check_snap("frame_update", dut_view(), e);
                end
            end
            tick_prev = (frame_tick === 1'b1);
            if (tick_prev) tick_count++;
        end
    end

    // One video frame: buttons held, short iVS low pulse, then settle.
    task automatic frame(input bit u1, input bit d1, input bit u2, input bit d2);
        int t0;
        @(posedge clk); #1;
        p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
        model_frame(u1, d1, u2, d2);
        exp_q.push_back(model_view());
        t0 = tick_count;
        vs = 1'b0;
        repeat (2) @(posedge clk);
        #1 vs = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_int("one_tick_per_frame", tick_count - t0, 1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        model_start();
        check_snap("start_transition", dut_view(), model_view());
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        snap_t rst_snap;
        model_reset();
        rst_snap = model_view();
        repeat (3) @(posedge clk);
        #1;
        check_snap("reset_values", dut_view(), rst_snap);
        check_int("reset_tick", int'(frame_tick), 0);
        rst = 1'b0;

        // Idle frames: nothing moves, one strobe per iVS fall.
        for (int i = 0; i < 5; i++) frame(1'b1, 1'b0, 1'b0, 1'b1);

        pulse_start();
        check_int("serve_state", int'(state), 1);

        // Steer pad2 down then press both buttons; steer pad1 into the ball path.
        for (int i = 0; i < 260; i++) begin
            if (i < 25)      frame(1'b0, 1'b0, 1'b0, 1'b1);
            else if (i < 35) frame(1'b0, 1'b0, 1'b1, 1'b1);
            else if (i >= 60 && i < 92) frame(1'b0, 1'b1, 1'b0, 1'b0);
            else             frame(1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Both paddles parked at the top: misses pile up until someone wins.
        for (int i = 0; i < 6000 && m_st != 4; i++) frame(1'b1, 1'b0, 1'b1, 1'b0);
        check_int("game_over_state", int'(state), 4);
        check_int("winner", int'(winner), m_w);

        // Frozen in OVER, then restart.
        for (int i = 0; i < 3; i++) frame(1'b0, 1'b1, 1'b0, 1'b1);
        pulse_start();

        // Random button play.
        for (int i = 0; i < 300; i++)
            frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Get back into PLAY then reset in the middle of a cycle.
        if (m_st == 4 || m_st == 0) pulse_start();
        for (int i = 0; i < 400 && m_st != 2; i++) frame(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) frame(1'b1, 1'b0, 1'b0, 1'b1);
        check_int("in_play_before_reset", int'(state), m_st);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_snap("async_reset", dut_view(), rst_snap);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        begin
            int t0;
            t0 = tick_count;
            repeat (10) @(posedge clk);
            #1;
            check_int("no_tick_after_reset", tick_count - t0, 0);
        end
        for (int i = 0; i < 2; i++) frame(1'b0, 1'b1, 1'b1, 1'b0);

        repeat (4) @(posedge clk);
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
